// File: rtl/serial_subtractor_pkg.sv
// Shared types for the bit-serial subtractor: FSM state encoding and default width.
package serial_subtractor_pkg;

  localparam int unsigned DEFAULT_WIDTH = 8;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    BUSY = 2'b01,
    DONE = 2'b10
  } state_e;

endpackage

// File: rtl/serial_subtractor_if.sv
// Start/busy/done handshake plus operand and result buses of the serial subtractor.
interface serial_subtractor_if #(
  parameter int unsigned WIDTH = 8
);

  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] diff;
  logic             borrow;

  modport master (
    output start, a, b,
    input  busy, done, diff, borrow
  );

  modport slave (
    input  start, a, b,
    output busy, done, diff, borrow
  );

endinterface

// File: rtl/full_subtractor.sv
// One-bit full subtractor cell: d = a - b - bin with borrow out.
module full_subtractor (
  input  logic a,
  input  logic b,
  input  logic bin,
  output logic d,
  output logic bout
);

  assign d    = a ^ b ^ bin;
  assign bout = (~a & b) | (~(a ^ b) & bin);

endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial unsigned a - b, LSB first, one bit per clock through a single
// full-subtractor cell; diff/borrow update only when all bits are done.
module serial_subtractor
  import serial_subtractor_pkg::*;
#(
  parameter int unsigned WIDTH = DEFAULT_WIDTH
) (
  input logic           clk,
  input logic           rst_n,
  serial_subtractor_if.slave bus
);

  localparam int unsigned CNT_W = $clog2(WIDTH);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

  state_e           state;
  state_e           state_next;
  logic [WIDTH-1:0] a_sr;
  logic [WIDTH-1:0] b_sr;
  logic [WIDTH-1:0] res;
  logic [WIDTH-1:0] res_next;
  logic [CNT_W-1:0] cnt;
  logic             bin;
  logic             d;
  logic             bout;
  logic             busy_q;
  logic             done_q;
  logic [WIDTH-1:0] diff_q;
  logic             borrow_q;

  logic             load;
  logic             step;
  logic             last;
  logic             busy_next;
  logic             done_next;

  full_subtractor u_fs (
    .a    (a_sr[0]),
    .b    (b_sr[0]),
    .bin  (bin),
    .d    (d),
    .bout (bout)
  );

  assign res_next = {d, res[WIDTH-1:1]};

  // Next-state and control decode; DONE accepts start just like IDLE
  always_comb begin
    state_next = state;
    load       = 1'b0;
    step       = 1'b0;
    last       = 1'b0;
    busy_next  = 1'b0;
    done_next  = 1'b0;
    case (state)
      IDLE, DONE: begin
        if (bus.start) begin
          load       = 1'b1;
          busy_next  = 1'b1;
          state_next = BUSY;
        end else begin
          state_next = IDLE;
        end
      end
      BUSY: begin
        step = 1'b1;
        if (cnt == CNT_LAST) begin
          last       = 1'b1;
          done_next  = 1'b1;
          state_next = DONE;
        end else begin
          busy_next  = 1'b1;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // State, datapath and registered outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      a_sr     <= '0;
      b_sr     <= '0;
      res      <= '0;
      cnt      <= '0;
      bin      <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      diff_q   <= '0;
      borrow_q <= 1'b0;
    end else begin
      state  <= state_next;
      busy_q <= busy_next;
      done_q <= done_next;
      if (load) begin
        a_sr <= bus.a;
        b_sr <= bus.b;
        res  <= '0;
        cnt  <= '0;
        bin  <= 1'b0;
      end else if (step) begin
        a_sr <= {1'b0, a_sr[WIDTH-1:1]};
        b_sr <= {1'b0, b_sr[WIDTH-1:1]};
        res  <= res_next;
        bin  <= bout;
        // Hold the counter at zero after the last bit so it never wraps
        cnt  <= last ? '0 : cnt + CNT_W'(1);
        if (last) begin
          diff_q   <= res_next;
          borrow_q <= bout;
        end
      end
    end
  end

  assign bus.busy   = busy_q;
  assign bus.done   = done_q;
  assign bus.diff   = diff_q;
  assign bus.borrow = borrow_q;

endmodule

// File: tb/tb_serial_subtractor.sv
// Scoreboard bench for serial_subtractor: driver queues hand-computed results,
// a negedge monitor pops and checks them whenever done pulses.
module tb_serial_subtractor;

  localparam int unsigned W = 8;

  typedef struct {
    logic [W-1:0] diff;
    logic         borrow;
    int           cyc;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  serial_subtractor_if #(.WIDTH(W)) bus ();

  serial_subtractor #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int   cyc = 0;
  int   n_vec = 0;
  int   n_bad = 0;
  exp_t sb[$];
  exp_t mon_e;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_vec++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, required 0x%0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // Monitor: every done pulse must match the oldest queued expectation
  always @(negedge clk) begin
    if (rst_n) begin
      if (bus.busy && bus.done) begin
        n_vec++;
        n_bad++;
        $display("FAIL busy_done_overlap: got busy=1 done=1, required not both (cycle %0d)", cyc);
      end
      if (bus.done) begin
        if (sb.size() == 0) begin
          n_vec++;
          n_bad++;
          $display("FAIL unexpected_done: got done=1, required 0 (cycle %0d)", cyc);
        end else begin
          mon_e = sb.pop_front();
          check("diff", 32'(bus.diff), 32'(mon_e.diff));
          check("borrow", 32'(bus.borrow), 32'(mon_e.borrow));
          check("done_cycle", 32'(cyc), 32'(mon_e.cyc));
        end
      end
    end
  end

  // Issue one start pulse and queue the expected result W cycles after capture
  task automatic launch(input logic [W-1:0] av, input logic [W-1:0] bv,
                        input logic [W-1:0] dv, input logic bw);
    @(negedge clk);
    bus.start = 1'b1;
    bus.a     = av;
    bus.b     = bv;
    @(posedge clk);
    #1;
    sb.push_back('{dv, bw, cyc + W});
    bus.start = 1'b0;
    check("busy_after_capture", 32'(bus.busy), 32'd1);
  endtask

  task automatic drain();
    int k;
    k = 0;
    while (sb.size() != 0 && k < 40) begin
      @(negedge clk);
      k++;
    end
    if (sb.size() != 0) begin
      n_vec++;
      n_bad++;
      $display("FAIL drain_timeout: got %0d pending results, required 0", sb.size());
      sb.delete();
    end
    @(negedge clk);
  endtask

  initial begin
    int t0;
    bus.start = 1'b0;
    bus.a     = '0;
    bus.b     = '0;
    #12;
    check("reset_busy", 32'(bus.busy), 32'd0);
    check("reset_done", 32'(bus.done), 32'd0);
    check("reset_diff", 32'(bus.diff), 32'd0);
    check("reset_borrow", 32'(bus.borrow), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // Directed vectors
    launch(8'd100, 8'd37,  8'h3F, 1'b0); drain();
    launch(8'd37,  8'd100, 8'hC1, 1'b1); drain();
    launch(8'd0,   8'd1,   8'hFF, 1'b1); drain();
    launch(8'h55,  8'h55,  8'h00, 1'b0); drain();
    launch(8'hFF,  8'h00,  8'hFF, 1'b0); drain();
    launch(8'h80,  8'h7F,  8'h01, 1'b0); drain();

    // start re-pulsed at T0+3 while busy is ignored
    launch(8'd100, 8'd37, 8'h3F, 1'b0);
    @(posedge clk);
    @(negedge clk);
    bus.start = 1'b1;
    bus.a     = 8'd200;
    bus.b     = 8'd1;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    check("busy_ignores_start", 32'(bus.busy), 32'd1);
    drain();

    // start held through DONE: second capture on the DONE edge
    @(negedge clk);
    bus.start = 1'b1;
    bus.a     = 8'd10;
    bus.b     = 8'd3;
    @(posedge clk);
    #1;
    t0 = cyc;
    sb.push_back('{8'h07, 1'b0, t0 + W});
    bus.a = 8'd3;
    bus.b = 8'd10;
    repeat (W + 1) @(posedge clk);
    #1;
    check("b2b_capture_cycle", 32'(cyc), 32'(t0 + W + 1));
    check("b2b_busy", 32'(bus.busy), 32'd1);
    sb.push_back('{8'hF9, 1'b1, cyc + W});
    bus.start = 1'b0;
    drain();

    // Reset asserted at T0+4 aborts the operation and clears the held result
    launch(8'd100, 8'd37, 8'h3F, 1'b0);
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b0;
    sb.delete();
    #1;
    check("abort_busy", 32'(bus.busy), 32'd0);
    check("abort_done", 32'(bus.done), 32'd0);
    check("abort_diff", 32'(bus.diff), 32'd0);
    check("abort_borrow", 32'(bus.borrow), 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (12) @(negedge clk);
    launch(8'd200, 8'd1, 8'hC7, 1'b0); drain();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got no completion, required finish before 200000");
    $fatal(1, "watchdog expired");
  end

endmodule
